csa_resolve_seq: RTL and testbench

//  Multi-cycle carry-propagate resolver for the multiplier datapath. It takes
//  the redundant sum/carry vector pair from the compressor tree and returns
//  the binary result, adding one CHUNK-bit slice per clock to keep the carry

---
 rtl/csa_resolve_seq.sv | 142 ++++++++++++++
 tb/tb_csa_resolve_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_seq.sv
// Multi-cycle carry-propagate resolver: adds a redundant sum/carry pair one CHUNK-bit slice per clock.
// Optional feature macro CSA_RESOLVE_ZSKIP_EN: zero-carry operands bypass the slice-add loop.
module csa_resolve_seq #(
  parameter int unsigned W     = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_sum_i,
  input  logic [W-1:0] in_carry_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W:0]   out_result_o,
  output logic         busy_o
);

  localparam int unsigned NCH = W / CHUNK;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW  = CHUNK + 1;

  if ((W % CHUNK) != 0) begin : g_bad_chunk
    $error("csa_resolve_seq: W must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [W-1:0]   carry_q, carry_d;
  logic [W:0]     res_q, res_d;
  logic [KW-1:0]  k_q, k_d;
  logic           cy_q, cy_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           accept_c;
  logic           last_c;
  logic [CW-1:0]  slice_c;

  // Ready is a decode of the state register, masked while reset is held.
  assign in_ready_o   = (state_q == S_IDLE) && !rst_i;
  assign accept_c     = in_valid_i && in_ready_o;
  assign last_c       = (k_q == KW'(NCH - 1));
  assign slice_c      = {1'b0, sum_q[k_q*CHUNK +: CHUNK]}
                      + {1'b0, carry_q[k_q*CHUNK +: CHUNK]}
                      + CW'(cy_q);
  assign out_valid_o  = out_valid_q;
  assign out_result_o = res_q;
  assign busy_o       = busy_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
`ifdef CSA_RESOLVE_ZSKIP_EN
          state_d = (in_carry_i == '0) ? S_DONE : S_ADD;
`else
          state_d = S_ADD;
`endif
        end
      end
      S_ADD:   if (last_c) state_d = S_DONE;
      S_DONE:  if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    res_d       = res_q;
    k_d         = k_q;
    cy_d        = cy_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          sum_d   = in_sum_i;
          carry_d = in_carry_i;
          k_d     = '0;
          cy_d    = 1'b0;
          res_d   = '0;
`ifdef CSA_RESOLVE_ZSKIP_EN
          if (in_carry_i == '0) begin
            res_d       = {1'b0, in_sum_i};
            out_valid_d = 1'b1;
          end
`endif
        end
      end
      S_ADD: begin
        res_d[k_q*CHUNK +: CHUNK] = slice_c[CHUNK-1:0];
        cy_d = slice_c[CHUNK];
        k_d  = last_c ? '0 : k_q + KW'(1);
        if (last_c) begin
          res_d[W]    = slice_c[CHUNK];
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready_i) out_valid_d = 1'b0;
      end
      default: out_valid_d = 1'b0;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q       <= '0;
      carry_q     <= '0;
      res_q       <= '0;
      k_q         <= '0;
      cy_q        <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      k_q         <= k_d;
      cy_q        <= cy_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Self-checking bench for csa_resolve_seq (W=32, CHUNK=8): directed vector table plus
// hand-written reset, back-to-back and reset-during-add sequences.
module tb_csa_resolve_seq;

  localparam int W   = 32;
  localparam int NCH = 4;
`ifdef CSA_RESOLVE_ZSKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_sum;
  logic [W-1:0]  in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    out_result;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] s;
    logic [31:0] c;
    logic [32:0] exp;
    int          hold;
    bit          noise;
  } vec_t;

  vec_t vecs[10];

  csa_resolve_seq #(.W(32), .CHUNK(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_sum_i     (in_sum),
    .in_carry_i   (in_carry),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] c);
    if (ZSKIP && (c == 32'd0)) return 0;
    return NCH;
  endfunction

  // Called at the negedge right after the accept edge; waits for the result,
  // optionally stalls the consumer, then completes the output handshake.
  task automatic finish_txn(input logic [32:0] exp, input int lat, input int hold, input bit noise);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      check("busy_add", 33'(busy), 33'd1);
      check("in_ready_add", 33'(in_ready), 33'd0);
      if (noise) begin
        in_valid  = 1'b1;
        in_sum    = $urandom;
        in_carry  = $urandom;
        out_ready = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    check("latency", 33'(n), 33'(lat));
    check("out_valid", 33'(out_valid), 33'd1);
    check("out_result", out_result, exp);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        in_valid = 1'b1;
        in_sum   = $urandom;
        in_carry = $urandom;
      end
      @(negedge clk);
      check("hold_valid", 33'(out_valid), 33'd1);
      check("hold_result", out_result, exp);
      check("hold_in_ready", 33'(in_ready), 33'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 33'(out_valid), 33'd0);
    check("busy_idle", 33'(busy), 33'd0);
    check("in_ready_idle", 33'(in_ready), 33'd1);
  endtask

  task automatic do_txn(input logic [31:0] s, input logic [31:0] c, input logic [32:0] exp,
                        input int hold, input bit noise);
    check("ready_before", 33'(in_ready), 33'd1);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    @(negedge clk);
    in_valid = 1'b0;
    finish_txn(exp, exp_lat(c), hold, noise);
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] c;
    int          n;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, 0, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000, 5, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h0000_0000, 33'h0_1234_5678, 0, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789, 0, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 2, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000, 0, 1'b1};
    vecs[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 33'h0_FFFF_FFFF, 0, 1'b0};
    vecs[7] = '{32'h00FF_00FF, 32'h0001_0001, 33'h0_0100_0100, 1, 1'b1};
    vecs[8] = '{32'h0000_00FF, 32'h0000_0001, 33'h0_0000_0100, 0, 1'b0};
    vecs[9] = '{32'h00FF_FFFF, 32'h0000_0001, 33'h0_0100_0000, 0, 1'b0};

    // Reset with in_valid held high: nothing may be accepted
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 32'd5;
    in_carry  = 32'd3;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", 33'(in_ready), 33'd0);
      check("rst_busy", 33'(busy), 33'd0);
      check("rst_out_valid", 33'(out_valid), 33'd0);
      check("rst_out_result", out_result, 33'd0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_rst", 33'(in_ready), 33'd1);
    @(negedge clk);
    check("first_edge_accept", 33'(busy), 33'd1);
    in_valid = 1'b0;
    finish_txn(33'd8, exp_lat(32'd3), 0, 1'b0);

    for (int i = 0; i < 10; i++)
      do_txn(vecs[i].s, vecs[i].c, vecs[i].exp, vecs[i].hold, vecs[i].noise);

    // Reset after two add cycles discards the transaction
    in_valid = 1'b1;
    in_sum   = 32'hFFFF_FFFF;
    in_carry = 32'h0000_0001;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 33'(out_valid), 33'd0);
    check("mid_rst_out_result", out_result, 33'd0);
    check("mid_rst_busy", 33'(busy), 33'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 33'(in_ready), 33'd1);
    do_txn(32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789, 0, 1'b0);
    check("post_rst_out_valid", 33'(out_valid), 33'd0);

    // Back-to-back with in_valid and out_ready held high
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s = $urandom;
      c = $urandom;
      in_sum   = s;
      in_carry = c;
      check("b2b_ready", 33'(in_ready), 33'd1);
      @(negedge clk);
      check("b2b_accept", 33'(busy), 33'd1);
      in_sum   = ~s;
      in_carry = c ^ 32'h5A5A_5A5A;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_latency", 33'(n), 33'(exp_lat(c)));
      check("b2b_result", out_result, 33'(s) + 33'(c));
      @(negedge clk);
      check("b2b_valid_drop", 33'(out_valid), 33'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
